apb_arb_master: RTL

APB_ARB_MASTER -- requirements
Module: apb_arb_master

---
 rtl/apb_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/apb_arb_master.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and default sizes for the arbitrated APB master.
package apb_arb_pkg;

   localparam int unsigned DATA_W_DEF      = 8;
   localparam int unsigned ADD_W_DEF       = 8;
   localparam int unsigned TIMEOUT_CYC_DEF = 16;

   // Codes chosen so that {psel, penable} is the state code itself.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b10,
      ACCESS = 2'b11
   } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: first set req bit at or above rr_ptr, with wrap.
module rr_arbiter #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [NREQ-1:0]  gnt_c,
   output logic [IDX_W-1:0] gnt_idx_c
);

   int unsigned idx;
   logic        found;

   always_comb begin
      gnt_c     = '0;
      gnt_idx_c = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = 32'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[idx]) begin
            found          = 1'b1;
            gnt_c[idx]     = 1'b1;
            gnt_idx_c      = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/apb_arb_master.sv
// Round-robin arbitrated APB master: NREQ requesters share one APB port.
// Optional ACCESS timeout is built when APB_ARB_TIMEOUT_EN is defined.
module apb_arb_master
   import apb_arb_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned ADD_W       = ADD_W_DEF,
   parameter int unsigned NREQ        = 2,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         req_write,
   input  logic [NREQ*ADD_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]  req_wdata,
   output logic [NREQ-1:0]         done,
   output logic                    err,
   output logic [DATA_W-1:0]       rdata,
   output logic                    psel,
   output logic                    penable,
   output logic [ADD_W-1:0]        paddr,
   output logic                    pwrite,
   output logic [DATA_W-1:0]       pwdata,
   input  logic [DATA_W-1:0]       prdata,
   input  logic                    pready
);

   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   apb_state_e        state_q, state_d;
   logic              load_cmd, finish, tmo_hit_c;
   logic [NREQ-1:0]   gnt_c;
   logic [IDX_W-1:0]  gnt_idx_c;
   logic [ADD_W-1:0]  sel_addr_c;
   logic [DATA_W-1:0] sel_wdata_c;
   logic              sel_write_c;

   logic [ADD_W-1:0]  cmd_addr_q;
   logic [DATA_W-1:0] cmd_wdata_q;
   logic              cmd_write_q;
   logic [NREQ-1:0]   cmd_gnt_q;
   logic [IDX_W-1:0]  gnt_idx_q;
   logic [IDX_W-1:0]  rr_ptr_q;
   logic [NREQ-1:0]   done_q;
   logic [DATA_W-1:0] rdata_q;

   rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
      .req       (req),
      .rr_ptr    (rr_ptr_q),
      .gnt_c     (gnt_c),
      .gnt_idx_c (gnt_idx_c)
   );

   // Pick the granted requester's command fields off the flat buses.
   always_comb begin
      sel_addr_c  = '0;
      sel_wdata_c = '0;
      sel_write_c = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_c[i]) begin
            sel_addr_c  = req_addr[i*ADD_W +: ADD_W];
            sel_wdata_c = req_wdata[i*DATA_W +: DATA_W];
            sel_write_c = req_write[i];
         end
      end
   end

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      load_cmd = 1'b0;
      finish   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               load_cmd = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP:  state_d = ACCESS;
         ACCESS: begin
            if (pready || tmo_hit_c) begin
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Command capture, completion pulse, read data and pointer advance.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         cmd_write_q <= 1'b0;
         cmd_gnt_q   <= '0;
         gnt_idx_q   <= '0;
         rr_ptr_q    <= '0;
         done_q      <= '0;
         rdata_q     <= '0;
      end else begin
         done_q <= '0;
         if (load_cmd) begin
            cmd_addr_q  <= sel_addr_c;
            cmd_wdata_q <= sel_wdata_c;
            cmd_write_q <= sel_write_c;
            cmd_gnt_q   <= gnt_c;
            gnt_idx_q   <= gnt_idx_c;
         end
         if (finish) begin
            done_q   <= cmd_gnt_q;
            rr_ptr_q <= (gnt_idx_q == IDX_W'(NREQ-1)) ? '0 : gnt_idx_q + IDX_W'(1);
            if (pready && !cmd_write_q) rdata_q <= prdata;
         end
      end
   end

`ifdef APB_ARB_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             err_q;

   assign tmo_hit_c = (state_q == ACCESS) && !pready &&
                      (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

   // Counts ACCESS cycles already spent without pready.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= finish && !pready;
         if (state_q == ACCESS && !finish) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
         else                              tmo_cnt_q <= '0;
      end
   end

   assign err = err_q;
`else
   assign tmo_hit_c = 1'b0;
   assign err       = 1'b0;
`endif

   assign psel    = state_q[1];
   assign penable = state_q[0];
   assign paddr   = cmd_addr_q;
   assign pwrite  = cmd_write_q;
   assign pwdata  = cmd_wdata_q;
   assign done    = done_q;
   assign rdata   = rdata_q;

endmodule
